// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU with annul and stall handshake.
// Optional early-out for |divisor| > |dividend| enabled by DIV_EARLY_OUT_EN.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [4:0]  cnt;
    logic [4:0]  cnt_n;
    logic [31:0] rem_q;
    logic [31:0] rem_n;
    logic [31:0] quo_q;
    logic [31:0] quo_n;
    logic [31:0] dvs_q;
    logic [31:0] dvs_n;
    logic        neg_q;
    logic        neg_q_n;
    logic        neg_r;
    logic        neg_r_n;
    logic [63:0] res_n;
    logic        rdy_n;

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] part;
    logic [32:0] trial;
    logic        no_borrow;
    logic [31:0] step_rem;
    logic [31:0] step_quo;

    function automatic logic [63:0] signfix(
        input logic [31:0] q,
        input logic [31:0] r,
        input logic        nq,
        input logic        nr
    );
        logic [31:0] qf;
        logic [31:0] rf;
        qf = nq ? -q : q;
        rf = nr ? -r : r;
        return {rf, qf};
    endfunction

    assign a_abs = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign b_abs = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

    // Shifted partial remainder; its top bit set means the subtract cannot borrow.
    assign part      = {rem_q, quo_q[31]};
    assign trial     = part - {1'b0, dvs_q};
    assign no_borrow = part[32] | ~trial[32];
    assign step_rem  = no_borrow ? trial[31:0] : part[31:0];
    assign step_quo  = {quo_q[30:0], no_borrow};

    assign stallreq_o = ~rst & start_i & ~annul_i & (state != END);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem_q;
        quo_n   = quo_q;
        dvs_n   = dvs_q;
        neg_q_n = neg_q;
        neg_r_n = neg_r;
        res_n   = result_o;
        rdy_n   = ready_o;
        unique case (state)
            FREE: begin
                res_n = 64'h0;
                rdy_n = 1'b0;
                if (start_i && !annul_i) begin
                    neg_q_n = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    neg_r_n = signed_div_i & opdata1_i[31];
                    dvs_n   = b_abs;
                    cnt_n   = 5'd0;
                    if (opdata2_i == 32'h0) begin
                        state_n = BYZERO;
                        quo_n   = 32'h0;
                        rem_n   = 32'h0;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (b_abs > a_abs) begin
                        // Reuses the one-cycle skip path with the answer preloaded.
                        state_n = BYZERO;
                        quo_n   = 32'h0;
                        rem_n   = a_abs;
                    end
`endif
                    else begin
                        state_n = ON;
                        quo_n   = a_abs;
                        rem_n   = 32'h0;
                    end
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_n = FREE;
                    res_n   = 64'h0;
                    rdy_n   = 1'b0;
                end else begin
                    state_n = END;
                    res_n   = signfix(quo_q, rem_q, neg_q, neg_r);
                    rdy_n   = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_n = FREE;
                    cnt_n   = 5'd0;
                    res_n   = 64'h0;
                    rdy_n   = 1'b0;
                end else begin
                    rem_n = step_rem;
                    quo_n = step_quo;
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state_n = END;
                        res_n   = signfix(step_quo, step_rem, neg_q, neg_r);
                        rdy_n   = 1'b1;
                    end
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_n = FREE;
                    res_n   = 64'h0;
                    rdy_n   = 1'b0;
                end
            end
            default: begin
                state_n = FREE;
                res_n   = 64'h0;
                rdy_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 5'd0;
            rem_q    <= 32'h0;
            quo_q    <= 32'h0;
            dvs_q    <= 32'h0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= 64'h0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem_q    <= rem_n;
            quo_q    <= quo_n;
            dvs_q    <= dvs_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            result_o <= res_n;
            ready_o  <= rdy_n;
        end
    end

endmodule
